// File: rtl/fractcam_writer.sv
// rtl/fractcam_writer.sv - row writer that shifts ternary rules into a FracTCAM LUT array
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_valid   row-update request valid
//   wr_ready   request can be accepted this cycle (IDLE and not in reset)
//   wr_row     target row (group of 8 entries)
//   wr_value   ternary values, entry e at [e*TCAM_WIDTH +: TCAM_WIDTH]
//   wr_mask    care mask, same layout (1 = care)
//   wr_enable  per-row shift enable, one-hot on the target row while shifting
//   rules      shift data, bit c*8+e feeds column c of entry e
//   busy       high for the 32 shift cycles of an update
//   done       one-cycle pulse after the last shift cycle
//   err        qualifies done: the row was out of range
module fractcam_writer #(
    parameter int TCAM_WIDTH = 5,
    parameter int TCAM_DEPTH = 64,
    parameter int ROW_W      = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [ROW_W-1:0]              wr_row,
    input  logic [8*TCAM_WIDTH-1:0]       wr_value,
    input  logic [8*TCAM_WIDTH-1:0]       wr_mask,
    output logic [TCAM_DEPTH/8-1:0]       wr_enable,
    output logic [TCAM_WIDTH*8/5-1:0]     rules,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int          ROWS   = TCAM_DEPTH / 8;
    localparam int          COLS   = TCAM_WIDTH / 5;
    localparam logic [31:0] ROWS_U = 32'(ROWS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                    state, state_nx;
    logic [4:0]                k, k_nx;
    logic [ROW_W-1:0]          row_q;
    logic [8*TCAM_WIDTH-1:0]   value_q;
    logic [8*TCAM_WIDTH-1:0]   mask_q;
    logic                      done_q, done_nx;
    logic                      err_q, err_nx;
    logic                      accept;
    logic                      row_ok;
    logic                      shifting;

    assign row_ok = (32'(row_q) < ROWS_U);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= 5'd31;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            row_q   <= '0;
            value_q <= '0;
            mask_q  <= '0;
        end else begin
            state  <= state_nx;
            k      <= k_nx;
            done_q <= done_nx;
            err_q  <= err_nx;
            if (accept) begin
                row_q   <= wr_row;
                value_q <= wr_value;
                mask_q  <= wr_mask;
            end
        end
    end

    always_comb begin
        state_nx = state;
        k_nx     = k;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        accept   = 1'b0;
        wr_ready = (state == IDLE) && !rst;
        case (state)
            IDLE: begin
                if (wr_valid && wr_ready) begin
                    accept   = 1'b1;
                    state_nx = SHIFT;
                    k_nx     = 5'd31;
                end
            end
            SHIFT: begin
                if (k == 5'd0) begin
                    state_nx = IDLE;
                    k_nx     = 5'd31;
                    done_nx  = 1'b1;
                    err_nx   = !row_ok;
                end else begin
                    k_nx = k - 5'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Every output is a function of registered state only, additionally
    // forced low while reset is held so an aborted shift stops immediately.
    always_comb begin
        shifting  = (state == SHIFT) && !rst;
        busy      = shifting;
        done      = done_q && !rst;
        err       = err_q && !rst;
        wr_enable = '0;
        rules     = '0;
        for (int r = 0; r < ROWS; r++) begin
            wr_enable[r] = shifting && row_ok && (32'(row_q) == 32'(r));
        end
        // LUT address k is written with 1 when k matches the 5-bit ternary slice.
        for (int c = 0; c < COLS; c++) begin
            for (int e = 0; e < 8; e++) begin
                rules[c*8+e] = shifting &&
                    (((k ^ value_q[e*TCAM_WIDTH + c*5 +: 5]) &
                      mask_q[e*TCAM_WIDTH + c*5 +: 5]) == 5'd0);
            end
        end
    end

endmodule

// File: tb/tb_fractcam_writer.sv
// tb/tb_fractcam_writer.sv - self-checking bench for fractcam_writer
module tb_fractcam_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic        wr_ready, wr_ready2;
    logic [2:0]  wr_row;
    logic [39:0] wr_value, wr_mask;
    logic [7:0]  wr_enable;
    logic [5:0]  wr_enable2;
    logic [7:0]  rules, rules2;
    logic        busy, busy2, done, done2, err, err2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fractcam_writer #(.TCAM_WIDTH(5), .TCAM_DEPTH(64), .ROW_W(3)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_row(wr_row), .wr_value(wr_value), .wr_mask(wr_mask),
        .wr_enable(wr_enable), .rules(rules), .busy(busy), .done(done), .err(err)
    );

    // Six-row variant so rows 6 and 7 are out of range.
    fractcam_writer #(.TCAM_WIDTH(5), .TCAM_DEPTH(48), .ROW_W(3)) dut_small (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready2),
        .wr_row(wr_row), .wr_value(wr_value), .wr_mask(wr_mask),
        .wr_enable(wr_enable2), .rules(rules2), .busy(busy2), .done(done2), .err(err2)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: presents a request, follows its 32 shift cycles,
    // captures the LUT contents written to each entry (pats[e][k]) and returns
    // at the negedge of the done cycle.
    task automatic run_update(input logic [2:0] row, input logic [39:0] val,
                              input logic [39:0] msk, output logic [7:0][31:0] pats);
        logic [7:0] exp_en;
        logic [5:0] exp_en2;
        logic       exp_err2;
        exp_en   = 8'd1 << row;
        exp_en2  = (row < 3'd6) ? (6'd1 << row) : 6'd0;
        exp_err2 = (row >= 3'd6);
        wr_row   = row;
        wr_value = val;
        wr_mask  = msk;
        wr_valid = 1'b1;
        chk("ready_at_accept", 64'(wr_ready), 64'd1);
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                wr_row   = ~row;
                wr_value = 40'({$urandom(), $urandom()});
                wr_mask  = 40'({$urandom(), $urandom()});
            end
            if (i == 31) wr_valid = 1'b0;
            chk("busy", 64'(busy), 64'd1);
            chk("ready_in_shift", 64'(wr_ready), 64'd0);
            chk("done_in_shift", 64'(done), 64'd0);
            chk("wr_enable", 64'(wr_enable), 64'(exp_en));
            chk("wr_enable_small", 64'(wr_enable2), 64'(exp_en2));
            chk("busy_small", 64'(busy2), 64'd1);
            for (int e = 0; e < 8; e++) pats[e][31-i] = rules[e];
            @(negedge clk);
        end
        chk("done", 64'(done), 64'd1);
        chk("err", 64'(err), 64'd0);
        chk("ready_after", 64'(wr_ready), 64'd1);
        chk("busy_after", 64'(busy), 64'd0);
        chk("idle_enable", 64'(wr_enable), 64'd0);
        chk("idle_rules", 64'(rules), 64'd0);
        chk("done_small", 64'(done2), 64'd1);
        chk("err_small", 64'(err2), 64'(exp_err2));
    endtask

    typedef struct {
        logic [2:0]       row;
        logic [39:0]      val;
        logic [39:0]      msk;
        logic [7:0][31:0] pat;
    } vec_t;

    vec_t             tbl[3];
    logic [7:0][31:0] got;
    logic [4:0]       key, v5, m5;
    logic             exp_m;

    initial begin
        for (int t = 0; t < 3; t++) begin
            for (int e = 0; e < 8; e++) tbl[t].pat[e] = 32'hFFFF_FFFF;
        end
        tbl[0].row = 3'd2; tbl[0].val = 40'h15;            tbl[0].msk = 40'h1F;
        tbl[0].pat[0] = 32'h0020_0000;
        tbl[1].row = 3'd0; tbl[1].val = 40'h3 << 15;       tbl[1].msk = 40'h3 << 15;
        tbl[1].pat[3] = 32'h8888_8888;
        tbl[2].row = 3'd7; tbl[2].val = 40'h0;             tbl[2].msk = 40'h1F << 25;
        tbl[2].pat[5] = 32'h0000_0001;

        rst = 1'b1; wr_valid = 1'b0; wr_row = '0; wr_value = '0; wr_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(wr_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_enable", 64'(wr_enable), 64'd0);
        chk("rst_rules", 64'(rules), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(wr_ready), 64'd1);

        // Directed vectors, issued back to back.
        for (int t = 0; t < 3; t++) begin
            run_update(tbl[t].row, tbl[t].val, tbl[t].msk, got);
            for (int e = 0; e < 8; e++) chk($sformatf("vec%0d_entry%0d", t, e), 64'(got[e]), 64'(tbl[t].pat[e]));
        end

        // Back-to-back rows 1 then 5; the task checks enables, single done.
        run_update(3'd1, 40'h0, 40'h0, got);
        run_update(3'd5, 40'h0, 40'h0, got);
        @(negedge clk);
        chk("no_second_done", 64'(done), 64'd0);

        // Reset during shift cycle 15 aborts with no done.
        wr_row = 3'd4; wr_value = '0; wr_mask = '0; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        repeat (14) @(negedge clk);
        chk("busy_cycle15", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_enable", 64'(wr_enable), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_ready", 64'(wr_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_release", 64'(wr_ready), 64'd1);
        for (int i = 0; i < 20; i++) begin
            chk("abort_quiet", 64'({done, busy}), 64'd0);
            @(negedge clk);
        end

        // Random rules written through the LUT model, then searched.
        for (int n = 0; n < 25; n++) begin
            logic [2:0]  r;
            logic [39:0] v, m;
            r = 3'($urandom_range(0, 7));
            v = 40'({$urandom(), $urandom()});
            m = 40'({$urandom(), $urandom()});
            run_update(r, v, m, got);
            for (int e = 0; e < 8; e++) begin
                v5  = v[e*5 +: 5];
                m5  = m[e*5 +: 5];
                key = 5'($urandom());
                if ($urandom_range(0, 1) == 1) key = (v5 & m5) | (key & ~m5);
                exp_m = ((key & m5) == (v5 & m5));
                chk("lut_match", 64'(got[e][key]), 64'(exp_m));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
